unpacker_param: RTL and testbench
=================================

UNPACKER_PARAM -- requirements
Module: unpacker_param

Interface
REQ-001 SHALL have parameter IN_IFC_SZ_B, default 160, input word width in bytes.
REQ-002 SHALL have parameter OUT_IFC_SZ_B, default 32, output slice width in bytes.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_L  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port val  in  1  input word valid.
REQ-006 SHALL have port sop  in  1  first word of packet.
REQ-007 SHALL have port eop  in  1  last word of packet.
REQ-008 SHALL have port vbc  in  $clog2(IN_IFC_SZ_B+1)  valid byte count of input word.
REQ-009 SHALL have port data  in  IN_IFC_SZ_B*8  input word, byte 0 at bits [7:0].
REQ-010 SHALL have port ready  out  1  block can accept an input word this cycle.
REQ-011 SHALL have port out_val  out  1  output slice valid.
REQ-012 SHALL have port out_sop  out  1  first slice of packet.
REQ-013 SHALL have port out_eop  out  1  last slice of packet.
REQ-014 SHALL have port out_vbc  out  $clog2(OUT_IFC_SZ_B+1)  valid bytes in slice.
REQ-015 SHALL have port out_data  out  OUT_IFC_SZ_B*8  output slice.
REQ-016 SHALL have port out_ready  in  1  downstream accepts slice when out_val && out_ready.
REQ-017 SHALL have port err  out  1  sticky protocol error (see Configuration).

Function
REQ-018 SHALL accept an input word on a rising edge where val && ready; val while ready low is ignored and SHALL be held by the source.
REQ-019 SHALL implement FSM IDLE/SLICE: IDLE->SLICE on accept with vbc>0; SLICE->IDLE on last slice accepted with no new accept; SLICE->SLICE on last slice accepted with same-cycle new accept.
REQ-020 SHALL drive ready = (state==IDLE) || (last slice && out_val && out_ready), giving back-to-back words with no bubble.
REQ-021 SHALL present the first slice the cycle after accept (latency 1), out_val high throughout SLICE.
REQ-022 SHALL emit ceil(vbc/OUT_IFC_SZ_B) slices; slice k carries data[k*OUT_IFC_SZ_B*8 +: OUT_IFC_SZ_B*8].
REQ-023 SHALL set out_vbc = OUT_IFC_SZ_B on all slices but the last, and vbc - k*OUT_IFC_SZ_B on the last; bytes beyond out_vbc SHALL be zero.
REQ-024 SHALL assert out_sop only on slice 0 of a sop word and out_eop only on the last slice of an eop word.
REQ-025 SHALL hold out_data, out_vbc, out_sop, out_eop stable while out_val && !out_ready.
REQ-026 SHALL consume an accepted word with vbc==0 and emit no slices, staying in IDLE.
REQ-027 SHALL fail elaboration unless IN_IFC_SZ_B % OUT_IFC_SZ_B == 0 and OUT_IFC_SZ_B <= IN_IFC_SZ_B.

Reset
REQ-028 SHALL on reset_L low asynchronously force state IDLE, slice counter 0, captured word 0, out_val/out_sop/out_eop 0, out_vbc 0, out_data 0, err 0; ready SHALL be 1 once reset_L is high.
REQ-029 SHALL discard any partially unpacked word on reset mid-operation; no slices of it appear after release.

Configuration
REQ-030 SHALL, with UNPACKER_PARAM_ERR_CHK_EN defined, set err sticky on accept of: vbc > IN_IFC_SZ_B; !eop with vbc != IN_IFC_SZ_B; sop while a packet is open; non-sop word while no packet is open; cleared only by reset.
REQ-031 SHALL, without UNPACKER_PARAM_ERR_CHK_EN, tie err to 0 and contain no checking logic; data path behaviour is identical either way.

Structure
REQ-032 SHALL place the FSM state enum and slice-count helper function in package unpacker_pkg.
REQ-033 SHALL implement slice selection/zero-masking in sub-module unpacker_slice_sel (combinational, parametrised like the top).

Verification (IN=160, OUT=32)
REQ-034 64B sop+eop word, out_ready=1 -> 2 slices, out_vbc 32,32, out_sop on 1st, out_eop on 2nd, ready low 1 cycle.
REQ-035 161B packet (160+1) -> 5 slices vbc 32 (sop on 1st), then 1 slice vbc 1 with out_eop, bytes 1..31 zero.
REQ-036 out_ready low 3 cycles on slice 2 of 160B word -> slice 2 data/vbc stable, ready low, no slice lost.
REQ-037 Two 64B packets with val held -> 2nd accepted on edge of 1st packet's last slice; 4 consecutive out_val cycles.
REQ-038 reset_L low during slice 3 of 160B word -> outputs 0 immediately; after release ready=1, no residual slices.
REQ-039 With UNPACKER_PARAM_ERR_CHK_EN, accept vbc=200 -> err=1 next cycle and remains 1 until reset.

Source files
------------

// File: rtl/unpacker_pkg.sv
// unpacker_pkg
// Shared types and helpers for the unpacker_param block.
//   state_t     : unpacker FSM encoding (IDLE / SLICE)
//   slice_count : number of output slices needed to carry a byte count
package unpacker_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SLICE = 1'b1
  } state_t;

  // ceil(nbytes / slice_b); only ever evaluated with a constant slice_b.
  function automatic int unsigned slice_count(input int unsigned nbytes,
                                              input int unsigned slice_b);
    return (nbytes + slice_b - 32'd1) / slice_b;
  endfunction

endpackage

// File: rtl/unpacker_slice_sel.sv
// unpacker_slice_sel
// Combinational slice selector: picks slice 'idx' out of a captured input
// word, computes how many of its bytes are valid and zeroes the rest.
// Ports:
//   word       in  IN_IFC_SZ_B*8             captured input word
//   vbc        in  $clog2(IN_IFC_SZ_B+1)     valid bytes in the captured word
//   idx        in  IDX_W                     slice index
//   valid      in  1                         slice is being presented
//   slice_data out OUT_IFC_SZ_B*8            masked slice (zero when !valid)
//   slice_vbc  out $clog2(OUT_IFC_SZ_B+1)    valid bytes in the slice
module unpacker_slice_sel #(
  parameter int IN_IFC_SZ_B  = 160,
  parameter int OUT_IFC_SZ_B = 32,
  parameter int IDX_W        = 3
) (
  input  logic [IN_IFC_SZ_B*8-1:0]          word,
  input  logic [$clog2(IN_IFC_SZ_B+1)-1:0]  vbc,
  input  logic [IDX_W-1:0]                  idx,
  input  logic                              valid,
  output logic [OUT_IFC_SZ_B*8-1:0]         slice_data,
  output logic [$clog2(OUT_IFC_SZ_B+1)-1:0] slice_vbc
);

  localparam int VBC_W  = $clog2(IN_IFC_SZ_B + 1);
  localparam int OVBC_W = $clog2(OUT_IFC_SZ_B + 1);

  logic [VBC_W-1:0]          base;
  logic [VBC_W-1:0]          rem;
  logic [OUT_IFC_SZ_B*8-1:0] raw;

  // Byte offset of this slice; always below IN_IFC_SZ_B so it fits VBC_W.
  assign base = VBC_W'(idx) * VBC_W'(OUT_IFC_SZ_B);
  assign rem  = (vbc > base) ? (vbc - base) : '0;
  assign raw  = word[int'(idx)*OUT_IFC_SZ_B*8 +: OUT_IFC_SZ_B*8];

  always_comb begin
    slice_vbc  = '0;
    slice_data = '0;
    if (valid) begin
      slice_vbc = (rem >= VBC_W'(OUT_IFC_SZ_B)) ? OVBC_W'(OUT_IFC_SZ_B)
                                                 : OVBC_W'(rem);
      for (int b = 0; b < OUT_IFC_SZ_B; b++) begin
        slice_data[b*8 +: 8] = (OVBC_W'(b) < slice_vbc) ? raw[b*8 +: 8] : 8'h00;
      end
    end
  end

endmodule

// File: rtl/unpacker_param.sv
// unpacker_param
// Splits wide input words (IN_IFC_SZ_B bytes) into OUT_IFC_SZ_B-byte slices.
// A word is captured on accept and its slices are presented from the next
// cycle on; the next word can be accepted on the edge the last slice leaves,
// so a held-valid source streams with no bubble.
//
// Optional feature: define UNPACKER_PARAM_ERR_CHK_EN to enable the sticky
// protocol-error flag 'err'; without it err is tied low.
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   val/sop/eop/vbc/data    input word and its qualifiers
//   ready                   input word accepted when val && ready
//   out_val/out_sop/out_eop/out_vbc/out_data   output slice
//   out_ready               slice consumed when out_val && out_ready
//   err                     sticky protocol error
//   state_dbg               current FSM state, for observation
//
// Handshake: on both sides a transfer happens on a rising edge where valid
// and ready are both high. A source holding valid must keep its payload
// stable until that edge; this block keeps out_* stable while
// out_val && !out_ready.
module unpacker_param
  import unpacker_pkg::*;
#(
  parameter int IN_IFC_SZ_B  = 160,
  parameter int OUT_IFC_SZ_B = 32
) (
  input  logic                              clk,
  input  logic                              reset_L,
  input  logic                              val,
  input  logic                              sop,
  input  logic                              eop,
  input  logic [$clog2(IN_IFC_SZ_B+1)-1:0]  vbc,
  input  logic [IN_IFC_SZ_B*8-1:0]          data,
  output logic                              ready,
  output logic                              out_val,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [$clog2(OUT_IFC_SZ_B+1)-1:0] out_vbc,
  output logic [OUT_IFC_SZ_B*8-1:0]         out_data,
  input  logic                              out_ready,
  output logic                              err,
  output state_t                            state_dbg
);

  localparam int VBC_W = $clog2(IN_IFC_SZ_B + 1);
  localparam int NSL   = IN_IFC_SZ_B / OUT_IFC_SZ_B;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  if ((OUT_IFC_SZ_B < 1) || (OUT_IFC_SZ_B > IN_IFC_SZ_B) ||
      ((IN_IFC_SZ_B % OUT_IFC_SZ_B) != 0)) begin : g_bad_cfg
    $error("unpacker_param: IN_IFC_SZ_B must be a multiple of OUT_IFC_SZ_B");
  end

  state_t                    state, state_nxt;
  logic [IN_IFC_SZ_B*8-1:0]  cap_data;
  logic [VBC_W-1:0]          cap_vbc;
  logic                      cap_sop, cap_eop;
  logic [IDX_W-1:0]          idx, last_idx;
  logic [VBC_W-1:0]          vbc_eff;
  logic                      last_slice, accept, load, advance;

  // A count beyond the word size is treated as a full word so slicing never
  // walks off the end of the captured data.
  assign vbc_eff    = (vbc > VBC_W'(IN_IFC_SZ_B)) ? VBC_W'(IN_IFC_SZ_B) : vbc;
  assign last_slice = (idx == last_idx);
  assign out_val    = (state == ST_SLICE);
  assign ready      = (state == ST_IDLE) || (last_slice && out_val && out_ready);
  assign accept     = val && ready;
  assign load       = accept && (vbc != '0);
  assign advance    = out_val && out_ready && !last_slice;
  assign out_sop    = out_val && cap_sop && (idx == '0);
  assign out_eop    = out_val && cap_eop && last_slice;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SLICE;
      ST_SLICE: if (out_ready && last_slice) state_nxt = load ? ST_SLICE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cap_data <= '0;
      cap_vbc  <= '0;
      cap_sop  <= 1'b0;
      cap_eop  <= 1'b0;
      idx      <= '0;
      last_idx <= '0;
    end else if (load) begin
      cap_data <= data;
      cap_vbc  <= vbc_eff;
      cap_sop  <= sop;
      cap_eop  <= eop;
      idx      <= '0;
      last_idx <= IDX_W'(slice_count(32'(vbc_eff), 32'(OUT_IFC_SZ_B)) - 32'd1);
    end else if (advance) begin
      idx <= idx + 1'b1;
    end
  end

  unpacker_slice_sel #(
    .IN_IFC_SZ_B  (IN_IFC_SZ_B),
    .OUT_IFC_SZ_B (OUT_IFC_SZ_B),
    .IDX_W        (IDX_W)
  ) u_slice_sel (
    .word       (cap_data),
    .vbc        (cap_vbc),
    .idx        (idx),
    .valid      (out_val),
    .slice_data (out_data),
    .slice_vbc  (out_vbc)
  );

`ifdef UNPACKER_PARAM_ERR_CHK_EN
  logic pkt_open, bad_word, err_q;

  assign bad_word = (vbc > VBC_W'(IN_IFC_SZ_B)) ||
                    (!eop && (vbc != VBC_W'(IN_IFC_SZ_B))) ||
                    (sop && pkt_open) ||
                    (!sop && !pkt_open);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pkt_open <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      pkt_open <= !eop;
      if (bad_word) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unpacker_param.sv
// tb_unpacker_param
// Bench for unpacker_param at IN=160, OUT=32. Expected slices are queued
// when a word is driven and compared as each slice is consumed.
module tb_unpacker_param;
  import unpacker_pkg::*;

  localparam int IN_B  = 160;
  localparam int OUT_B = 32;
  localparam int VW    = $clog2(IN_B + 1);
  localparam int OVW   = $clog2(OUT_B + 1);
  localparam int EW    = 2 + OVW + OUT_B*8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  logic                val = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [VW-1:0]       vbc = '0;
  logic [IN_B*8-1:0]   data = '0;
  logic                ready, out_val, out_sop, out_eop, err, out_ready;
  logic [OVW-1:0]      out_vbc;
  logic [OUT_B*8-1:0]  out_data;
  state_t              state_dbg;

  logic rnd_mode = 1'b0, rdy_force = 1'b1, rdy_rand = 1'b1;
  assign out_ready = rnd_mode ? rdy_rand : rdy_force;

  unpacker_param #(.IN_IFC_SZ_B(IN_B), .OUT_IFC_SZ_B(OUT_B)) dut (
    .clk(clk), .reset_L(reset_L), .val(val), .sop(sop), .eop(eop), .vbc(vbc),
    .data(data), .ready(ready), .out_val(out_val), .out_sop(out_sop),
    .out_eop(out_eop), .out_vbc(out_vbc), .out_data(out_data),
    .out_ready(out_ready), .err(err), .state_dbg(state_dbg)
  );

  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, val_cnt = 0, run = 0, last_run = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  // scoreboard: a slice transfers on the edge after this negedge
  always @(negedge clk) begin
    if (out_val) begin
      val_cnt++;
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (out_val && out_ready) begin
      if (exp_q.size() == 0) check("extra_slice", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("slice", {out_sop, out_eop, out_vbc, out_data}, mon_e);
      end
    end
  end

  // Reference slicing; counts beyond the word size are taken as a full word.
  task automatic push_exp(input logic s, input logic e, input int n, input logic [IN_B*8-1:0] d);
    int nb, ns;
    nb = (n > IN_B) ? IN_B : n;
    ns = (nb + OUT_B - 1) / OUT_B;
    for (int k = 0; k < ns; k++) begin
      int sv;
      logic [OUT_B*8-1:0] sl;
      sv = (k == ns - 1) ? nb - k*OUT_B : OUT_B;
      sl = d[k*OUT_B*8 +: OUT_B*8];
      for (int b = 0; b < OUT_B; b++) if (b >= sv) sl[b*8 +: 8] = 8'h00;
      exp_q.push_back({s && (k == 0), e && (k == ns - 1), OVW'(sv), sl});
    end
  endtask

  // driver: call #1 after a rising edge; returns #1 after the accept edge
  task automatic send_word(input logic s, input logic e, input int n, input logic [IN_B*8-1:0] d);
    logic got;
    got = 1'b0;
    push_exp(s, e, n, d);
    val = 1'b1; sop = s; eop = e; vbc = VW'(n); data = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    val = 1'b0; sop = 1'b0; eop = 1'b0; vbc = '0; data = '0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !out_val) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", {exp_q.size(), done}, {32'd0, 1'b1});
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_B*8-1:0] rand_word();
    logic [IN_B*8-1:0] w;
    for (int i = 0; i < IN_B/4; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  logic [IN_B*8-1:0] w, w2;
  int c0, nw, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_val", out_val, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_vbc_sop_eop", {out_vbc, out_sop, out_eop}, 0);
    check("rst_err", err, 0);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", ready, 1);

    // 64B sop+eop: two full slices, ready low for one cycle
    w = rand_word();
    send_word(1, 1, 64, w);
    check("lat1_out_val", out_val, 1);
    check("t64_ready_low", ready, 0);
    @(posedge clk);
    #1;
    check("t64_ready_back", ready, 1);
    wait_drain();

    // 161B packet: 160B word then 1B word
    w = rand_word();
    w2 = rand_word();
    send_word(1, 0, 160, w);
    send_word(0, 1, 1, w2);
    wait_drain();

    // stall three cycles on slice 2 of a 160B word
    w = rand_word();
    send_word(1, 1, 160, w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rdy_force = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_slice2", {out_sop, out_eop, out_vbc, out_data},
            {1'b0, 1'b0, OVW'(32), w[2*OUT_B*8 +: OUT_B*8]});
      check("stall_ready", {out_val, ready}, 2'b10);
    end
    rdy_force = 1'b1;
    wait_drain();

    // two 64B packets back to back with val held
    send_word(1, 1, 64, rand_word());
    c0 = acc_cyc;
    send_word(1, 1, 64, rand_word());
    check("b2b_accept_gap", acc_cyc - c0, 2);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("b2b_out_val_run", last_run, 4);

    // zero-byte word is consumed without output
    send_word(1, 1, 0, rand_word());
    check("vbc0_no_val", {out_val, ready}, 2'b01);
    @(posedge clk);
    #1;
    check("vbc0_idle", {out_val, ready}, 2'b01);

    // reset during slice 3 of a 160B word
    w = rand_word();
    send_word(1, 1, 160, w);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_pending", exp_q.size(), 2);
    reset_L = 1'b0;
    #1;
    check("rst_mid_outputs", {out_val, out_sop, out_eop, out_vbc, out_data}, 0);
    exp_q.delete();
    c0 = val_cnt;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    #1;
    check("rst_mid_ready", ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("rst_mid_no_residual", val_cnt - c0, 0);

    // random packets with random downstream back-pressure
    rnd_mode = 1'b1;
    for (int p = 0; p < 12; p++) begin
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) begin
        n = (i == nw - 1) ? $urandom_range(1, IN_B) : IN_B;
        send_word(i == 0, i == nw - 1, n, rand_word());
      end
    end
    wait_drain();
    rnd_mode = 1'b0;

`ifdef UNPACKER_PARAM_ERR_CHK_EN
    check("err_clean", err, 0);
    send_word(1, 1, 200, rand_word());
    check("err_set", err, 1);
    wait_drain();
    check("err_sticky", err, 1);
    send_word(1, 1, 64, rand_word());
    wait_drain();
    check("err_sticky_clean_pkt", err, 1);
    reset_L = 1'b0;
    #1;
    check("err_reset_clear", err, 0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
`else
    check("err_tied_low", err, 0);
`endif

    @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
